// File: rtl/wb_host_sequencer_if.sv
// Wishbone classic bus bundle between the host sequencer (master) and
// the RRAM IMC slave port. Signal names keep the initiator's view.
interface wb_host_sequencer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            wbm_cyc_o;
  logic            wbm_stb_o;
  logic            wbm_we_o;
  logic [AW-1:0]   wbm_adr_o;
  logic [DW-1:0]   wbm_dat_o;
  logic [DW/8-1:0] wbm_sel_o;
  logic [DW-1:0]   wbm_dat_i;
  logic            wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_host_sequencer.sv
// Wishbone classic single-transfer initiator. One accepted command becomes
// one bus cycle; the result is offered on a valid/ready response port.
// Optional ack timeout is compiled in with the WB_HOST_TIMEOUT_EN macro.
module wb_host_sequencer #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [AW-1:0]         cmd_adr,
  input  logic [DW-1:0]         cmd_wdata,
  input  logic [DW/8-1:0]       cmd_sel,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  // Wishbone master side
  wb_host_sequencer_if.master   wb,
  // status
  output logic                  busy,
  output logic [CNT_W-1:0]      txn_count
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_cyc;
  logic              r_stb;
  logic              r_we;
  logic [AW-1:0]     r_adr;
  logic [DW-1:0]     r_dat;
  logic [DW/8-1:0]   r_sel;
  logic              r_rsp_valid;
  logic [DW-1:0]     r_rsp_rdata;
  logic [CNT_W-1:0]  r_txn_count;

`ifdef WB_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]     r_wait;
  logic              r_rsp_err;
`endif

  // Sequencer FSM: accept, run one bus cycle, hold response until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_txn_count <= '0;
`ifdef WB_HOST_TIMEOUT_EN
      r_wait      <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= cmd_we;
            r_adr   <= cmd_adr;
            r_dat   <= cmd_wdata;
            r_sel   <= cmd_sel;
`ifdef WB_HOST_TIMEOUT_EN
            r_wait  <= '0;
`endif
            r_state <= BUS;
          end
        end
        BUS: begin
          // ack on the timeout edge still counts as a normal completion
          if (wb.wbm_ack_i) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_rdata <= r_we ? '0 : wb.wbm_dat_i;
            r_rsp_valid <= 1'b1;
            r_txn_count <= r_txn_count + 1'b1;
`ifdef WB_HOST_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            r_state     <= RESP;
          end
`ifdef WB_HOST_TIMEOUT_EN
          else if (r_wait == WAIT_LAST) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_txn_count <= r_txn_count + 1'b1;
            r_state     <= RESP;
          end else begin
            r_wait      <= r_wait + 1'b1;
          end
`endif
        end
        RESP: begin
          // no accept here: the next command waits for the IDLE edge
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready    = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign txn_count    = r_txn_count;
`ifdef WB_HOST_TIMEOUT_EN
  assign rsp_err      = r_rsp_err;
`else
  assign rsp_err      = 1'b0;
`endif

  assign wb.wbm_cyc_o = r_cyc;
  assign wb.wbm_stb_o = r_stb;
  assign wb.wbm_we_o  = r_we;
  assign wb.wbm_adr_o = r_adr;
  assign wb.wbm_dat_o = r_dat;
  assign wb.wbm_sel_o = r_sel;

endmodule

// File: tb/tb_wb_host_sequencer.sv
// Directed bench for wb_host_sequencer: read, write with wait states,
// response backpressure, ack timeout (or indefinite wait), asynchronous
// reset mid-transfer and transaction counter wrap (CNT_W=4).
module tb_wb_host_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CNT_W = 4;
  localparam int TOUT = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0]   cmd_adr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_sel;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic            busy;
  logic [CNT_W-1:0] txn_count;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] exp_cnt;

  wb_host_sequencer_if #(.AW(AW), .DW(DW)) wb ();

  wb_host_sequencer #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .wb(wb.master), .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full read transfer with ack one cycle after the accept edge
  task automatic do_read(input logic [AW-1:0] adr, input logic [DW-1:0] data,
                         input logic [CNT_W-1:0] cnt);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = adr; cmd_sel = 4'hF;
    step();
    chk("rd_cyc", wb.wbm_cyc_o, 1);
    chk("rd_adr", wb.wbm_adr_o, adr);
    cmd_valid = 1'b0;
    wb.wbm_ack_i = 1'b1; wb.wbm_dat_i = data;
    step();
    wb.wbm_ack_i = 1'b0;
    chk("rd_done_cyc", wb.wbm_cyc_o, 0);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rdata", rsp_rdata, data);
    chk("rd_err", rsp_err, 0);
    chk("rd_cnt", txn_count, cnt);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rd_rsp_clear", rsp_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0;
    cmd_wdata = '0; cmd_sel = '0; rsp_ready = 1'b0;
    wb.wbm_ack_i = 1'b0; wb.wbm_dat_i = '0;
    #1;
    chk("rst_cyc", wb.wbm_cyc_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", txn_count, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_stb", wb.wbm_stb_o, 0);

    // Read, ack one cycle after accept
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0004; cmd_sel = 4'hF;
    step();
    chk("r1_cyc", wb.wbm_cyc_o, 1);
    chk("r1_stb", wb.wbm_stb_o, 1);
    chk("r1_we", wb.wbm_we_o, 0);
    chk("r1_adr", wb.wbm_adr_o, 32'h3000_0004);
    chk("r1_cmd_ready", cmd_ready, 0);
    chk("r1_busy", busy, 1);
    cmd_valid = 1'b0; cmd_adr = 32'hDEAD_BEEF;
    wb.wbm_ack_i = 1'b1; wb.wbm_dat_i = 32'hA5A5_0001;
    step();
    wb.wbm_ack_i = 1'b0;
    chk("r1_cyc_drop", wb.wbm_cyc_o, 0);
    chk("r1_stb_drop", wb.wbm_stb_o, 0);
    chk("r1_rsp_valid", rsp_valid, 1);
    chk("r1_rdata", rsp_rdata, 32'hA5A5_0001);
    chk("r1_err", rsp_err, 0);
    chk("r1_cnt", txn_count, 1);
    chk("r1_adr_keep", wb.wbm_adr_o, 32'h3000_0004);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("r1_rsp_clear", rsp_valid, 0);
    chk("r1_idle_ready", cmd_ready, 1);

    // Write with three wait states
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0000;
    cmd_wdata = 32'h0000_00FF; cmd_sel = 4'hF;
    step();
    cmd_valid = 1'b0; cmd_wdata = 32'h1234_5678; cmd_sel = 4'h1;
    for (int i = 0; i < 4; i++) begin
      chk("w_cyc", wb.wbm_cyc_o, 1);
      chk("w_we", wb.wbm_we_o, 1);
      chk("w_adr", wb.wbm_adr_o, 32'h3000_0000);
      chk("w_dat", wb.wbm_dat_o, 32'h0000_00FF);
      chk("w_sel", wb.wbm_sel_o, 4'hF);
      if (i == 3) begin
        wb.wbm_ack_i = 1'b1; wb.wbm_dat_i = 32'h5555_AAAA;
      end
      step();
    end
    wb.wbm_ack_i = 1'b0;
    chk("w_cyc_drop", wb.wbm_cyc_o, 0);
    chk("w_we_drop", wb.wbm_we_o, 0);
    chk("w_dat_keep", wb.wbm_dat_o, 32'h0000_00FF);
    chk("w_rsp_valid", rsp_valid, 1);
    chk("w_rdata", rsp_rdata, 0);
    chk("w_err", rsp_err, 0);
    chk("w_cnt", txn_count, 2);

    // Backpressure: response held, next command waits
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0008; cmd_sel = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_cyc", wb.wbm_cyc_o, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_rsp_clear", rsp_valid, 0);
    chk("bp_no_accept_in_resp", wb.wbm_cyc_o, 0);
    chk("bp_cmd_ready_back", cmd_ready, 1);
    step();
    chk("bp_2nd_cyc", wb.wbm_cyc_o, 1);
    chk("bp_2nd_adr", wb.wbm_adr_o, 32'h3000_0008);
    cmd_valid = 1'b0;
    wb.wbm_ack_i = 1'b1; wb.wbm_dat_i = 32'h1234_5678;
    step();
    wb.wbm_ack_i = 1'b0;
    chk("bp_2nd_rdata", rsp_rdata, 32'h1234_5678);
    chk("bp_2nd_cnt", txn_count, 3);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Stray ack while idle
    wb.wbm_ack_i = 1'b1;
    step();
    wb.wbm_ack_i = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_cnt", txn_count, 3);
    chk("stray_rsp", rsp_valid, 0);

    // No ack: timeout when enabled, otherwise wait indefinitely
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_000C;
    step();
    cmd_valid = 1'b0;
`ifdef WB_HOST_TIMEOUT_EN
    for (int i = 0; i < TOUT - 1; i++) step();
    chk("to_cyc_before", wb.wbm_cyc_o, 1);
    step();
    chk("to_cyc_drop", wb.wbm_cyc_o, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_err", rsp_err, 1);
    chk("to_rdata", rsp_rdata, 0);
    chk("to_cnt", txn_count, 4);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_adr = 32'h3000_0010;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mid_bus_cyc", wb.wbm_cyc_o, 1);
`else
    for (int i = 0; i < 1000; i++) step();
    chk("hang_cyc", wb.wbm_cyc_o, 1);
    chk("hang_busy", busy, 1);
    chk("hang_cnt", txn_count, 3);
`endif

    // Asynchronous reset in the middle of a bus cycle
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", wb.wbm_cyc_o, 0);
    chk("arst_stb", wb.wbm_stb_o, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_cnt", txn_count, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    wb.wbm_ack_i = 1'b1;
    step();
    wb.wbm_ack_i = 1'b0;
    chk("arst_stray_busy", busy, 0);
    chk("arst_stray_cnt", txn_count, 0);
    do_read(32'h3000_0004, 32'h0BAD_F00D, 4'd1);

    // Counter wrap: 16 reads starting from count 1 cross 15 -> 0
    exp_cnt = 4'd1;
    for (int i = 0; i < 16; i++) begin
      exp_cnt = exp_cnt + 4'd1;
      do_read(32'h3000_0100 + 32'(i * 4), 32'hC000_0000 + 32'(i), exp_cnt);
    end
    chk("wrap_final_cnt", txn_count, 1);
    chk("wrap_busy", busy, 0);
    chk("wrap_cmd_ready", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
